video_alpha_feeder: RTL and testbench

VIDEO_ALPHA_FEEDER -- requirements
Module: video_alpha_feeder

---
 rtl/video_alpha_feeder.sv | 71 +++++++
 tb/tb_video_alpha_feeder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/video_alpha_feeder.sv
// Joins a source and a destination pixel stream into one registered pair for the alpha mixer,
// tagging the last pixel of each line. Define VIDEO_PER_PIXEL_ALPHA_EN to take the rate from a_data[31:24].
module video_alpha_feeder #(
    parameter int LINE_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          a_data,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [31:0]          b_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [7:0]           global_rate,
    input  logic [LINE_BITS-1:0] line_len,
    output logic [31:0]          mix_a,
    output logic [31:0]          mix_b,
    output logic [7:0]           mix_rate,
    output logic                 mix_valid,
    input  logic                 mix_ready,
    output logic                 mix_eol
);

    logic                 stage_free;
    logic                 xfer;
    logic [LINE_BITS-1:0] pix_cnt;
    logic [LINE_BITS-1:0] last_idx;
    logic                 at_last;
    logic [7:0]           rate_sel;

    assign stage_free = !mix_valid || mix_ready;
    assign xfer       = !reset && a_valid && b_valid && stage_free;

    // Both streams see the same ready so neither can be consumed without the other.
    assign a_ready = xfer;
    assign b_ready = xfer;

    // line_len==0 wraps to all-ones, giving a full 2^LINE_BITS line; >= also covers
    // a line_len shrunk below the current position mid-line.
    assign last_idx = line_len - LINE_BITS'(1);
    assign at_last  = (pix_cnt >= last_idx);

`ifdef VIDEO_PER_PIXEL_ALPHA_EN
    assign rate_sel = a_data[31:24];
`else
    assign rate_sel = global_rate;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: the data registers are reset too, so the mixer never sees stale pixels after reset.
            mix_a     <= '0;
            mix_b     <= '0;
            mix_rate  <= '0;
            mix_valid <= 1'b0;
            mix_eol   <= 1'b0;
            pix_cnt   <= '0;
        end else if (xfer) begin
            mix_a     <= a_data;
            mix_b     <= b_data;
            mix_rate  <= rate_sel;
            mix_valid <= 1'b1;
            mix_eol   <= at_last;
            pix_cnt   <= at_last ? '0 : pix_cnt + LINE_BITS'(1);
        end else if (mix_ready) begin
            mix_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_alpha_feeder.sv
// Directed self-checking bench for video_alpha_feeder (LINE_BITS=3); expected rate follows
// VIDEO_PER_PIXEL_ALPHA_EN when the bench is compiled with that macro.
module tb_video_alpha_feeder;

    localparam int LB = 3;

`ifdef VIDEO_PER_PIXEL_ALPHA_EN
    localparam logic [7:0] EXP_RATE = 8'h80;
`else
    localparam logic [7:0] EXP_RATE = 8'h40;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   a_data, b_data;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [7:0]    global_rate;
    logic [LB-1:0] line_len;
    logic [31:0]   mix_a, mix_b;
    logic [7:0]    mix_rate;
    logic          mix_valid, mix_ready, mix_eol;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    video_alpha_feeder #(.LINE_BITS(LB)) dut (
        .clk(clk), .reset(reset),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .global_rate(global_rate), .line_len(line_len),
        .mix_a(mix_a), .mix_b(mix_b), .mix_rate(mix_rate),
        .mix_valid(mix_valid), .mix_ready(mix_ready), .mix_eol(mix_eol)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // One pair transferred with mix_ready high; checks ready, then the registered result.
    task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b, input logic exp_eol);
        a_data = a;
        b_data = b;
        a_valid = 1'b1;
        b_valid = 1'b1;
        mix_ready = 1'b1;
        #1;
        check({tag, ".a_ready"}, 32'(a_ready), 32'd1);
        check({tag, ".b_ready"}, 32'(b_ready), 32'd1);
        tick();
        check({tag, ".valid"}, 32'(mix_valid), 32'd1);
        check({tag, ".mix_a"}, mix_a, a);
        check({tag, ".mix_b"}, mix_b, b);
        check({tag, ".eol"}, 32'(mix_eol), 32'(exp_eol));
    endtask

    initial begin
        reset = 1'b1;
        a_data = 32'h1234_5678;
        b_data = 32'h9ABC_DEF0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        mix_ready = 1'b1;
        global_rate = 8'h40;
        line_len = 3'd4;

        // Reset state; ready must stay low while reset is high even with both inputs valid
        tick();
        check("rst.a_ready", 32'(a_ready), 32'd0);
        check("rst.b_ready", 32'(b_ready), 32'd0);
        check("rst.valid", 32'(mix_valid), 32'd0);
        check("rst.eol", 32'(mix_eol), 32'd0);
        check("rst.mix_a", mix_a, 32'd0);
        check("rst.mix_b", mix_b, 32'd0);
        check("rst.rate", 32'(mix_rate), 32'd0);

        // Only A valid: no transfer for 5 cycles
        reset = 1'b0;
        b_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("join.a_ready", 32'(a_ready), 32'd0);
            check("join.b_ready", 32'(b_ready), 32'd0);
            tick();
            check("join.valid", 32'(mix_valid), 32'd0);
        end
        send("join.first", 32'hA000_0001, 32'hB000_0001, 1'b0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        check("join.drain", 32'(mix_valid), 32'd0);

        // line_len=4, 10 back-to-back pairs: eol on pixels 3 and 7
        do_reset();
        line_len = 3'd4;
        for (int i = 0; i < 10; i++)
            send($sformatf("line4.p%0d", i), 32'h0100_0000 + 32'(i), 32'h0200_0000 + 32'(i), (i % 4) == 3);

        // Backpressure: pixel 9 held for 3 cycles while new data waits
        mix_ready = 1'b0;
        a_data = 32'hDEAD_0010;
        b_data = 32'hBEEF_0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.a_ready", 32'(a_ready), 32'd0);
            tick();
            check("stall.valid", 32'(mix_valid), 32'd1);
            check("stall.mix_a", mix_a, 32'h0100_0009);
            check("stall.mix_b", mix_b, 32'h0200_0009);
            check("stall.eol", 32'(mix_eol), 32'd0);
        end
        // Release: the waiting pair is accepted in the same cycle as the drain (index 2, then 3)
        send("release.p10", 32'hDEAD_0010, 32'hBEEF_0010, 1'b0);
        send("release.p11", 32'hDEAD_0011, 32'hBEEF_0011, 1'b1);

        // line_len shrinks to 2 with the counter at 2: next pixel ends the line and wraps
        send("shrink.p0", 32'h0300_0000, 32'h0400_0000, 1'b0);
        send("shrink.p1", 32'h0300_0001, 32'h0400_0001, 1'b0);
        line_len = 3'd2;
        send("shrink.p2", 32'h0300_0002, 32'h0400_0002, 1'b1);
        send("shrink.p3", 32'h0300_0003, 32'h0400_0003, 1'b0);
        send("shrink.p4", 32'h0300_0004, 32'h0400_0004, 1'b1);

        // line_len=1: every pixel ends a line
        line_len = 3'd1;
        for (int i = 0; i < 3; i++)
            send($sformatf("len1.p%0d", i), 32'h0500_0000 + 32'(i), 32'h0600_0000 + 32'(i), 1'b1);

        // Rate source, full a_data pass-through, rate held against later global_rate changes
        global_rate = 8'h40;
        send("rate", 32'h80FF_FFFF, 32'h0000_0000, 1'b1);
        check("rate.capture", 32'(mix_rate), 32'(EXP_RATE));
        mix_ready = 1'b0;
        global_rate = 8'h11;
        a_data = 32'h11FF_FFFF;
        tick();
        check("rate.hold", 32'(mix_rate), 32'(EXP_RATE));
        check("rate.hold_a", mix_a, 32'h80FF_FFFF);

        // Reset after pixel 2 of a 4-pixel line: held pixel discarded, line restarts
        do_reset();
        line_len = 3'd4;
        for (int i = 0; i < 3; i++)
            send($sformatf("midrst.pre%0d", i), 32'h0700_0000 + 32'(i), 32'h0800_0000 + 32'(i), 1'b0);
        reset = 1'b1;
        #1;
        check("midrst.a_ready", 32'(a_ready), 32'd0);
        tick();
        check("midrst.valid", 32'(mix_valid), 32'd0);
        check("midrst.eol", 32'(mix_eol), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            send($sformatf("midrst.p%0d", i), 32'h0900_0000 + 32'(i), 32'h0A00_0000 + 32'(i), i == 3);

        // line_len=0 with LINE_BITS=3: eol every 8th pixel
        do_reset();
        line_len = 3'd0;
        for (int i = 0; i < 16; i++)
            send($sformatf("len0.p%0d", i), 32'h0B00_0000 + 32'(i), 32'h0C00_0000 + 32'(i), (i % 8) == 7);

        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        check("final.drain", 32'(mix_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
